// File: rtl/seq_pkg.sv
// Shared widths and state encodings for the sequence generator and its 111 detector.
package seq_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  // Index of the final frame bit, as seen by the bit counter
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    Z0 = 2'd0,
    Z1 = 2'd1,
    Z2 = 2'd2
  } det_t;

endpackage

// File: rtl/seq_111_ref.sv
// Overlapping "111" detector with a Mealy output; also usable as a golden model.
module seq_111_ref
  import seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic S,
  output logic Y
);

  det_t z, z_n;

  // Detector history register; clr drops history at frame boundaries
  always_ff @(posedge clk) begin
    if (reset || clr) z <= Z0;
    else              z <= z_n;
  end

  // Next history and Mealy output for the bit currently presented
  always_comb begin
    z_n = z;
    Y   = 1'b0;
    if (en) begin
      case (z)
        Z0:      z_n = S ? Z1 : Z0;
        Z1:      z_n = S ? Z2 : Z0;
        Z2: begin
          z_n = S ? Z2 : Z0;
          Y   = S;
        end
        default: z_n = Z0;
      endcase
    end
  end

endmodule

// File: rtl/sequence_gen_111.sv
// Serialises a 16-bit word LSB first with a matching expected-111 flag.
// Optional feature macro: SEQ_GEN_COUNT_EN adds the hit_count port.
module sequence_gen_111
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data,
  output logic              S,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic              Y_exp
`ifdef SEQ_GEN_COUNT_EN
  ,
  output logic [CNT_W-1:0]  hit_count
`endif
);

  state_t             state, state_n;
  logic [WORD_W-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               s_n, valid_n, done_n, busy_n;
  logic               accept;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      S         <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      S         <= s_n;
      bit_valid <= valid_n;
      done      <= done_n;
      busy      <= busy_n;
    end
  end

  // Next state and next output values; bit 0 leaves on the accepting edge
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    s_n     = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    busy_n  = busy;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
          shreg_n = WORD_W'(data >> 1);
          cnt_n   = '0;
          s_n     = data[0];
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        if (cnt == LAST_BIT) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n   = CNT_W'(cnt + 1'b1);
          s_n     = shreg[0];
          shreg_n = WORD_W'(shreg >> 1);
          valid_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  seq_111_ref u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (bit_valid),
    .S     (S),
    .Y     (Y_exp)
  );

`ifdef SEQ_GEN_COUNT_EN
  // Per-frame Y_exp pulse count, saturating, held until the next acceptance
  always_ff @(posedge clk) begin
    if (reset)                              hit_count <= '0;
    else if (accept)                        hit_count <= '0;
    else if (Y_exp && (hit_count != '1))    hit_count <= CNT_W'(hit_count + 1'b1);
  end
`endif

endmodule

// File: tb/tb_sequence_gen_111.sv
// Self-checking bench for sequence_gen_111 (table of frames + scoreboard + corner sequences).
module tb_sequence_gen_111;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] data;
  logic        S, bit_valid, busy, done, Y_exp;
`ifdef SEQ_GEN_COUNT_EN
  logic [3:0]  hit_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic s;
    logic y;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic        inject;
    logic [15:0] other;
    logic [3:0]  hits;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  sequence_gen_111 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .S         (S),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .Y_exp     (Y_exp)
`ifdef SEQ_GEN_COUNT_EN
    ,
    .hit_count (hit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference serial model: LSB first, Y when two prior frame bits were 1
  task automatic push_frame(input logic [15:0] d);
    int run = 0;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.s = d[i];
      e.y = d[i] && (run >= 2);
      sb.push_back(e);
      run = d[i] ? run + 1 : 0;
    end
  endtask

  task automatic run_frame(input vec_t v);
    int   pulses = 0;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    data  = v.data;
    push_frame(v.data);
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = ~v.data;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bit_valid && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("d%04h_bit%0d_S", v.data, k), 32'(S), 32'(e.s));
        check($sformatf("d%04h_bit%0d_Y", v.data, k), 32'(Y_exp), 32'(e.y));
      end else begin
        check($sformatf("d%04h_bit%0d_valid", v.data, k), 32'(bit_valid), 32'd1);
      end
      check($sformatf("d%04h_bit%0d_busy", v.data, k), 32'(busy), 32'd1);
      pulses += int'(Y_exp);
      if (v.inject && k == 5) begin start = 1'b1; data = v.other; end
      if (v.inject && k == 6) begin start = 1'b0; data = ~v.data; end
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(bit_valid), 32'd0);
    check("done_S", 32'(S), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_Y", 32'(Y_exp), 32'd0);
    check($sformatf("d%04h_pulses", v.data), 32'(pulses), 32'(v.hits));
`ifdef SEQ_GEN_COUNT_EN
    check($sformatf("d%04h_hit_count", v.data), 32'(hit_count), 32'(v.hits));
`endif
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_valid", 32'(bit_valid), 32'd0);
`ifdef SEQ_GEN_COUNT_EN
    check("idle_hit_hold", 32'(hit_count), 32'(v.hits));
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_S"}, 32'(S), 32'd0);
    check({tag, "_valid"}, 32'(bit_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_Y"}, 32'(Y_exp), 32'd0);
`ifdef SEQ_GEN_COUNT_EN
    check({tag, "_hits"}, 32'(hit_count), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          p;
    vecs[0] = '{data: 16'h8756, inject: 1'b0, other: 16'h0000, hits: 4'd1};
    vecs[1] = '{data: 16'hFFFF, inject: 1'b0, other: 16'h0000, hits: 4'd14};
    vecs[2] = '{data: 16'h0000, inject: 1'b0, other: 16'h0000, hits: 4'd0};
    vecs[3] = '{data: 16'h7777, inject: 1'b0, other: 16'h0000, hits: 4'd4};
    vecs[4] = '{data: 16'h0FF0, inject: 1'b0, other: 16'h0000, hits: 4'd6};
    vecs[5] = '{data: 16'h8756, inject: 1'b1, other: 16'hFFFF, hits: 4'd1};

    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // Table of frames
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // start held high: back-to-back frames of 16'hFFFF, 18-clock period
    @(negedge clk);
    start = 1'b1;
    data  = 16'hFFFF;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      p = (c - 1) % 18;
      check($sformatf("cont_c%0d_valid", c), 32'(bit_valid), 32'(p < 16));
      check($sformatf("cont_c%0d_S", c), 32'(S), 32'(p < 16));
      check($sformatf("cont_c%0d_done", c), 32'(done), 32'(p == 16));
      check($sformatf("cont_c%0d_Y", c), 32'(Y_exp), 32'(p >= 2 && p < 16));
    end
    start = 1'b0;
    for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    check("cont_drain", 32'(busy), 32'd0);
    @(negedge clk);

    // Reset mid-frame at bit 8, with start also high: reset wins
    w = 16'h8756;
    start = 1'b1;
    data  = w;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("abort_bit%0d_S", k), 32'(S), 32'(w[k]));
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_quiet("abort");
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", c), 32'(done), 32'd0);
      check($sformatf("abort_idle%0d", c), 32'(busy), 32'd0);
    end
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_gen_111.md
SEQUENCE_GEN_111 -- requirements
Module: sequence_gen_111

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-004 SHALL have port data  input  16  frame word, captured when start is accepted.
REQ-005 SHALL have port S  output  1  serial bit stream, LSB first, registered.
REQ-006 SHALL have port bit_valid  output  1  high while S carries a frame bit.
REQ-007 SHALL have port busy  output  1  high from start acceptance through the DONE cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last bit.
REQ-009 SHALL have port Y_exp  output  1  expected "111" detector output for the bit currently on S.
REQ-010 SHALL have port hit_count  output  4  number of Y_exp pulses in the current or last frame (present only under SEQ_GEN_COUNT_EN).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 SHALL capture data into a 16-bit shift register, clear bit counter and detector history, and enter SHIFT on the next edge.
REQ-013 The first bit (data[0]) SHALL appear on S with bit_valid=1 in the cycle immediately after the accepting edge (latency 1 clock).
REQ-014 SHIFT SHALL present one bit per clock: bit index k = 0..15 on S; 4-bit counter increments each cycle.
REQ-015 After the cycle presenting bit 15, the FSM SHALL enter DONE for exactly one cycle: done=1, bit_valid=0, S=0, busy=1.
REQ-016 DONE SHALL always return to IDLE; start asserted during DONE SHALL be ignored (no back-to-back frames).
REQ-017 start during SHIFT SHALL be ignored; data changes after acceptance SHALL NOT affect the frame.
REQ-018 Outside SHIFT: S=0, bit_valid=0, Y_exp=0.
REQ-019 Y_exp SHALL be a Mealy output: 1 in the same cycle S=1, bit_valid=1 and the two previous frame bits were 1; overlapping (1111 gives two pulses).
REQ-020 Detector history SHALL NOT span frames; first two bits of a frame can never raise Y_exp.
REQ-021 Detector SHALL use three states Z0 (no 1s), Z1 (one 1), Z2 (two or more 1s); S=0 returns to Z0; S=1 advances Z0->Z1->Z2, Z2 stays Z2 with Y_exp=1.

Reset
REQ-022 reset SHALL force IDLE and S=0, bit_valid=0, busy=0, done=0, Y_exp=0, hit_count=0, detector Z0, counter 0.
REQ-023 reset SHALL take priority over start and abort any frame mid-SHIFT; no done pulse is produced for an aborted frame.

Configuration
REQ-024 Macro SEQ_GEN_COUNT_EN defined: hit_count port present; cleared on start acceptance; increments (saturating at 15) on each Y_exp pulse; held through DONE and IDLE until next acceptance.
REQ-025 Macro SEQ_GEN_COUNT_EN undefined: hit_count port and its logic absent; all other behaviour identical.

Structure
REQ-026 Shared package seq_pkg SHALL hold: WORD_W=16, CNT_W=4, FSM state typedef (IDLE/SHIFT/DONE), detector state typedef (Z0/Z1/Z2).
REQ-027 Detector SHALL be a sub-module seq_111_ref (inputs clk, reset, clr, en, S; output Y), reusable as a golden model for the 111 detector.

Verification
REQ-028 reset, then start with data=16'h8756 -> S over 16 cycles = 0,1,1,0,1,0,1,0,1,1,1,0,0,0,0,1; Y_exp=1 only at bit 10; done at cycle 17 after acceptance; hit_count=1.
REQ-029 data=16'hFFFF -> S all 1; Y_exp=1 at bits 2..15 (14 pulses); hit_count=14.
REQ-030 data=16'h0000 -> S all 0, bit_valid high 16 cycles, Y_exp never 1, hit_count=0.
REQ-031 start held high continuously with data=16'hFFFF -> frames separated by DONE + one IDLE cycle (period 18 clocks); Y_exp never set at bits 0,1 of the second frame.
REQ-032 reset asserted at bit 8 of 16'h8756 -> next cycle all outputs 0, FSM IDLE, no done pulse; a new start restarts at bit 0.
REQ-033 start pulsed during SHIFT with different data -> ignored; current frame completes unchanged.
